orange_stage_pc_mem_mdr_sp: RTL and testbench
=============================================

// Module: orange_stage_pc_mem_mdr_sp
// PURPOSE
//  Stage directly downstream of the ALU/ALUOut/RegA/RegB stage in the multicycle accumulator CPU.
//  Owns PC, SP, IR and MDR, and runs a handshaked memory FSM with a timeout.
//  Consumes ALUOut, BranchOut, ShouldBranch and RegB from the upstream stage.
//  Returns PC, SP and MDR to it as PCIn, SPIn and MDRIn.
// PARAMETERS
//  PC_RESET  16'h0000  PC value after reset
//  SP_RESET  16'hFFFE  SP value after reset
//  TIMEOUT   15        max BUSY cycles without MemAck before abort (1..255)
// PORTS
//  CLK           in   1   clock, rising edge
//  Reset         in   1   asynchronous, active-high; clears all state
//  ALUOutIn      in   16  registered ALU result (data address / SP value)
//  BranchIn      in   16  next-PC value
//  ShouldBranch  in   1   ALU branch condition
//  RegBIn        in   16  store data
//  PCWrite       in   1   unconditional PC load
//  PCWriteCond   in   1   PC load if ShouldBranch
//  SPWrite       in   1   SP <= ALUOutIn
//  IorD          in   1   address select: 0 = PC, 1 = ALUOutIn
//  MemRead       in   1   start read (sampled in IDLE only)
//  MemWrite      in   1   start write (sampled in IDLE only)
//  IRWrite       in   1   read data also loads IR (sampled with MemRead)
//  ErrClr        in   1   clears MemErr
//  MemAddr       out  16  memory address
//  MemWData      out  16  memory write data
//  MemReq        out  1   request valid
//  MemWe         out  1   1 = write
//  MemAck        in   1   memory completion
//  MemRData      in   16  read data; valid with MemAck
//  PCOut         out  16  program counter
//  SPOut         out  16  stack pointer
//  IROut         out  16  instruction register
//  MDROut        out  16  memory data register
//  MemBusy       out  1   1 in BUSY state
//  MemDone       out  1   one-cycle pulse in DONE state
//  MemErr        out  1   sticky error flag
// BEHAVIOUR
//  Reset (async) values:
//   PC = PC_RESET; SP = SP_RESET; IR, MDR, MemAddr and MemWData = 0.
//   MemReq, MemWe, MemDone, MemErr and the timeout counter = 0; FSM = IDLE.
//   A reset asserted mid-transaction drops MemReq immediately; the access is abandoned.
//  PC register:
//   At the clock edge, PC <= BranchIn if (PCWrite | (PCWriteCond & ShouldBranch)) & !MemBusy.
//   Otherwise PC holds.
//  SP register: SP <= ALUOutIn on SPWrite; not gated by MemBusy.
//  Memory FSM (states IDLE -> BUSY -> DONE -> IDLE):
//   IDLE, exactly one of MemRead/MemWrite high:
//    - latch MemAddr = IorD ? ALUOutIn : PC
//    - latch MemWData = RegBIn, MemWe = MemWrite
//    - latch the IRWrite qualifier; clear the counter; go to BUSY
//   IDLE, MemRead & MemWrite both high:
//    - no request is issued; MemErr is set; FSM stays in IDLE
//   BUSY:
//    - MemReq = 1; MemAddr, MemWData and MemWe are held stable
//    - counter increments each cycle
//   BUSY & MemAck:
//    - on a read, MDR <= MemRData
//    - on a read with IRWrite latched, IR <= MemRData as well
//    - go to DONE
//   BUSY, counter == TIMEOUT-1 and no MemAck:
//    - set MemErr; MDR and IR unchanged; go to DONE
//    - an ack arriving in that same cycle wins: no error
//   DONE:
//    - MemDone = 1, MemReq = 0; next state is IDLE
//    - MemRead/MemWrite are ignored in this cycle
//  MemAck outside BUSY is ignored.
//  Minimum latency: request seen in IDLE at cycle n gives BUSY at n+1.
//   With an ack in cycle n+1: DONE and valid MDR/IR at n+2; IDLE at n+3.
//  MemErr is cleared only by Reset or ErrClr.
//   If ErrClr and a set condition occur in the same cycle, set wins.
// TESTING
//  1 Reset: PCOut = 0000 and SPOut = FFFE; MemReq = 0; MemErr = 0.
//  2 Fetch with IorD=0, PC=0000, MemRead=1, IRWrite=1; MemAck one cycle later with RData=1234:
//    IR = MDR = 1234; MemDone pulses exactly once.
//  3 Store with IorD=1, ALUOut=0040, RegB=BEEF, MemWrite=1; ack delayed 5 cycles:
//    MemAddr = 0040, WData = BEEF and MemWe = 1 held for 5 cycles; MDR unchanged.
//  4 Read with no MemAck: MemErr rises after exactly 15 BUSY cycles, then DONE, then IDLE.
//    ErrClr clears MemErr.
//  5 PCWriteCond=1 with ShouldBranch 0 then 1, BranchIn=0020:
//    PC holds, then loads 0020; PCWrite during BUSY is ignored.
//  6 Reset asserted in BUSY: MemReq drops before the next clock edge; PC = 0000; FSM = IDLE.

Source files
------------

// File: rtl/orange_stage_pc_mem_mdr_sp.sv
// Purpose: PC/SP/IR/MDR stage of the multicycle accumulator CPU, with a
//          handshaked memory access FSM (IDLE -> BUSY -> DONE) and a timeout.
// Ports:
//   CLK, Reset                      clock (rising edge), async active-high reset
//   ALUOutIn, BranchIn, RegBIn      upstream data: address/SP value, next PC, store data
//   ShouldBranch                    upstream branch condition
//   PCWrite, PCWriteCond, SPWrite   register load controls
//   IorD, MemRead, MemWrite, IRWrite  memory access controls (sampled in IDLE)
//   ErrClr                          clears the sticky MemErr flag
//   MemAddr, MemWData, MemReq, MemWe  memory request side
//   MemAck, MemRData                memory response side
//   PCOut, SPOut, IROut, MDROut     architectural registers
//   MemBusy, MemDone, MemErr        access status
module orange_stage_pc_mem_mdr_sp #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [15:0] SP_RESET = 16'hFFFE,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] ALUOutIn,
    input  logic [15:0] BranchIn,
    input  logic        ShouldBranch,
    input  logic [15:0] RegBIn,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic        SPWrite,
    input  logic        IorD,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        IRWrite,
    input  logic        ErrClr,
    output logic [15:0] MemAddr,
    output logic [15:0] MemWData,
    output logic        MemReq,
    output logic        MemWe,
    input  logic        MemAck,
    input  logic [15:0] MemRData,
    output logic [15:0] PCOut,
    output logic [15:0] SPOut,
    output logic [15:0] IROut,
    output logic [15:0] MDROut,
    output logic        MemBusy,
    output logic        MemDone,
    output logic        MemErr
);

    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [15:0]      pc_q, pc_d;
    logic [15:0]      sp_q, sp_d;
    logic [15:0]      ir_q, ir_d;
    logic [15:0]      mdr_q, mdr_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             irw_q, irw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_RESET;
            sp_q    <= SP_RESET;
            ir_q    <= 16'h0000;
            mdr_q   <= 16'h0000;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            irw_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
            irw_q   <= irw_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        req_d   = req_q;
        done_d  = 1'b0;
        err_d   = err_q;
        irw_d   = irw_q;
        cnt_d   = cnt_q;

        // PC is frozen while an access is in flight so the fetch address stays coherent
        if ((PCWrite | (PCWriteCond & ShouldBranch)) & ~req_q) begin
            pc_d = BranchIn;
        end

        if (SPWrite) begin
            sp_d = ALUOutIn;
        end

        // Clear first so any set condition below overrides it
        if (ErrClr) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (MemRead & MemWrite) begin
                    err_d = 1'b1;
                end else if (MemRead ^ MemWrite) begin
                    addr_d  = IorD ? ALUOutIn : pc_q;
                    wdata_d = RegBIn;
                    we_d    = MemWrite;
                    irw_d   = IRWrite & MemRead;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An ack in the final allowed cycle takes priority over the timeout
                if (MemAck) begin
                    if (!we_q) begin
                        mdr_d = MemRData;
                        if (irw_q) begin
                            ir_d = MemRData;
                        end
                    end
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign MemAddr  = addr_q;
    assign MemWData = wdata_q;
    assign MemReq   = req_q;
    assign MemWe    = we_q;
    assign PCOut    = pc_q;
    assign SPOut    = sp_q;
    assign IROut    = ir_q;
    assign MDROut   = mdr_q;
    assign MemBusy  = req_q;
    assign MemDone  = done_q;
    assign MemErr   = err_q;

endmodule

// File: tb/tb_orange_stage_pc_mem_mdr_sp.sv
// Directed-vector bench for orange_stage_pc_mem_mdr_sp.
module tb_orange_stage_pc_mem_mdr_sp;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [15:0] ALUOutIn, BranchIn, RegBIn, MemRData;
    logic        ShouldBranch, PCWrite, PCWriteCond, SPWrite, IorD;
    logic        MemRead, MemWrite, IRWrite, ErrClr, MemAck;
    logic [15:0] MemAddr, MemWData, PCOut, SPOut, IROut, MDROut;
    logic        MemReq, MemWe, MemBusy, MemDone, MemErr;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 CLK = ~CLK;

    orange_stage_pc_mem_mdr_sp dut (
        .CLK(CLK), .Reset(Reset), .ALUOutIn(ALUOutIn), .BranchIn(BranchIn),
        .ShouldBranch(ShouldBranch), .RegBIn(RegBIn), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .SPWrite(SPWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .ErrClr(ErrClr),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemReq(MemReq), .MemWe(MemWe),
        .MemAck(MemAck), .MemRData(MemRData), .PCOut(PCOut), .SPOut(SPOut),
        .IROut(IROut), .MDROut(MDROut), .MemBusy(MemBusy), .MemDone(MemDone),
        .MemErr(MemErr)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        ALUOutIn = 16'h0; BranchIn = 16'h0; RegBIn = 16'h0; MemRData = 16'h0;
        ShouldBranch = 0; PCWrite = 0; PCWriteCond = 0; SPWrite = 0; IorD = 0;
        MemRead = 0; MemWrite = 0; IRWrite = 0; ErrClr = 0; MemAck = 0;
        tick();
        tick();
        vec_cnt++; if (PCOut !== 16'h0000) begin err_cnt++; $display("FAIL reset_pc got %h want 0000", PCOut); end
        vec_cnt++; if (SPOut !== 16'hFFFE) begin err_cnt++; $display("FAIL reset_sp got %h want fffe", SPOut); end
        vec_cnt++; if (MemReq !== 1'b0) begin err_cnt++; $display("FAIL reset_req got %b want 0", MemReq); end
        vec_cnt++; if (MemErr !== 1'b0) begin err_cnt++; $display("FAIL reset_err got %b want 0", MemErr); end
        vec_cnt++; if ({IROut, MDROut} !== 32'h0) begin err_cnt++; $display("FAIL reset_ir_mdr got %h want 0", {IROut, MDROut}); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        int done_seen = 0;
        IorD = 0; MemRead = 1; IRWrite = 1;
        tick();
        MemRead = 0; IRWrite = 0;
        done_seen += int'(MemDone);
        vec_cnt++; if (MemReq !== 1'b1 || MemBusy !== 1'b1) begin err_cnt++; $display("FAIL fetch_busy got req=%b busy=%b want 1/1", MemReq, MemBusy); end
        vec_cnt++; if (MemAddr !== 16'h0000 || MemWe !== 1'b0) begin err_cnt++; $display("FAIL fetch_addr got %h we=%b want 0000 we=0", MemAddr, MemWe); end
        MemAck = 1; MemRData = 16'h1234;
        tick();
        MemAck = 0; MemRData = 16'hDEAD;
        done_seen += int'(MemDone);
        vec_cnt++; if (IROut !== 16'h1234) begin err_cnt++; $display("FAIL fetch_ir got %h want 1234", IROut); end
        vec_cnt++; if (MDROut !== 16'h1234) begin err_cnt++; $display("FAIL fetch_mdr got %h want 1234", MDROut); end
        vec_cnt++; if (MemReq !== 1'b0) begin err_cnt++; $display("FAIL fetch_done_req got %b want 0", MemReq); end
        tick();
        done_seen += int'(MemDone);
        tick();
        done_seen += int'(MemDone);
        vec_cnt++; if (done_seen != 1) begin err_cnt++; $display("FAIL fetch_done_pulses got %0d want 1", done_seen); end
    endtask

    task automatic test_store();
        IorD = 1; ALUOutIn = 16'h0040; RegBIn = 16'hBEEF; MemWrite = 1;
        tick();
        MemWrite = 0; ALUOutIn = 16'h7777; RegBIn = 16'h8888; IorD = 0;
        for (int i = 0; i < 5; i++) begin
            vec_cnt++;
            if (MemReq !== 1'b1 || MemAddr !== 16'h0040 || MemWData !== 16'hBEEF || MemWe !== 1'b1) begin
                err_cnt++;
                $display("FAIL store_hold[%0d] got req=%b addr=%h wdata=%h we=%b want 1/0040/beef/1",
                         i, MemReq, MemAddr, MemWData, MemWe);
            end
            if (i == 4) begin MemAck = 1; MemRData = 16'h5555; end
            tick();
        end
        MemAck = 0;
        vec_cnt++; if (MemDone !== 1'b1) begin err_cnt++; $display("FAIL store_done got %b want 1", MemDone); end
        vec_cnt++; if (MDROut !== 16'h1234 || IROut !== 16'h1234) begin err_cnt++; $display("FAIL store_mdr got %h/%h want 1234/1234", MDROut, IROut); end
        tick();
    endtask

    task automatic test_timeout();
        IorD = 0; MemRead = 1; IRWrite = 1;
        tick();
        MemRead = 0; IRWrite = 0;
        for (int i = 1; i <= 15; i++) begin
            vec_cnt++;
            if (MemBusy !== 1'b1 || MemErr !== 1'b0) begin
                err_cnt++;
                $display("FAIL timeout_busy[%0d] got busy=%b err=%b want 1/0", i, MemBusy, MemErr);
            end
            tick();
        end
        vec_cnt++; if (MemErr !== 1'b1 || MemDone !== 1'b1 || MemBusy !== 1'b0) begin err_cnt++; $display("FAIL timeout_done got err=%b done=%b busy=%b want 1/1/0", MemErr, MemDone, MemBusy); end
        vec_cnt++; if (MDROut !== 16'h1234 || IROut !== 16'h1234) begin err_cnt++; $display("FAIL timeout_mdr got %h/%h want 1234/1234", MDROut, IROut); end
        tick();
        vec_cnt++; if (MemDone !== 1'b0 || MemErr !== 1'b1 || MemBusy !== 1'b0) begin err_cnt++; $display("FAIL timeout_idle got done=%b err=%b busy=%b want 0/1/0", MemDone, MemErr, MemBusy); end
        ErrClr = 1;
        tick();
        ErrClr = 0;
        vec_cnt++; if (MemErr !== 1'b0) begin err_cnt++; $display("FAIL errclr got %b want 0", MemErr); end

        // Ack in the final allowed cycle: no error, data captured
        MemRead = 1;
        tick();
        MemRead = 0;
        for (int i = 1; i <= 15; i++) begin
            if (i == 15) begin MemAck = 1; MemRData = 16'hA5A5; end
            tick();
        end
        MemAck = 0;
        vec_cnt++; if (MemErr !== 1'b0 || MDROut !== 16'hA5A5 || IROut !== 16'h1234) begin err_cnt++; $display("FAIL late_ack got err=%b mdr=%h ir=%h want 0/a5a5/1234", MemErr, MDROut, IROut); end
        tick();

        // Both strobes high: error, no request; set beats simultaneous clear
        MemRead = 1; MemWrite = 1; ErrClr = 1;
        tick();
        vec_cnt++; if (MemErr !== 1'b1 || MemBusy !== 1'b0) begin err_cnt++; $display("FAIL both_strobes got err=%b busy=%b want 1/0", MemErr, MemBusy); end
        MemRead = 0; MemWrite = 0;
        tick();
        ErrClr = 0;
        vec_cnt++; if (MemErr !== 1'b0) begin err_cnt++; $display("FAIL both_errclr got %b want 0", MemErr); end
    endtask

    task automatic test_branch();
        BranchIn = 16'h0020; PCWriteCond = 1; ShouldBranch = 0;
        tick();
        vec_cnt++; if (PCOut !== 16'h0000) begin err_cnt++; $display("FAIL cond_not_taken got %h want 0000", PCOut); end
        ShouldBranch = 1;
        tick();
        PCWriteCond = 0; ShouldBranch = 0;
        vec_cnt++; if (PCOut !== 16'h0020) begin err_cnt++; $display("FAIL cond_taken got %h want 0020", PCOut); end
        IorD = 0; MemRead = 1;
        tick();
        MemRead = 0; PCWrite = 1; BranchIn = 16'h0099; SPWrite = 1; ALUOutIn = 16'h3000;
        tick();
        PCWrite = 0; SPWrite = 0;
        vec_cnt++; if (PCOut !== 16'h0020 || MemAddr !== 16'h0020) begin err_cnt++; $display("FAIL pc_busy got pc=%h addr=%h want 0020/0020", PCOut, MemAddr); end
        vec_cnt++; if (SPOut !== 16'h3000) begin err_cnt++; $display("FAIL sp_busy got %h want 3000", SPOut); end
        MemAck = 1; MemRData = 16'h0F0F;
        tick();
        MemAck = 0;
        tick();
        PCWrite = 1; BranchIn = 16'h0100;
        tick();
        PCWrite = 0;
        vec_cnt++; if (PCOut !== 16'h0100) begin err_cnt++; $display("FAIL pc_idle got %h want 0100", PCOut); end
    endtask

    task automatic test_reset_busy();
        IorD = 0; MemRead = 1;
        tick();
        MemRead = 0;
        vec_cnt++; if (MemReq !== 1'b1) begin err_cnt++; $display("FAIL rb_req_before got %b want 1", MemReq); end
        #2;
        Reset = 1;
        #1;
        vec_cnt++; if (MemReq !== 1'b0 || MemBusy !== 1'b0) begin err_cnt++; $display("FAIL rb_req_drop got req=%b busy=%b want 0/0", MemReq, MemBusy); end
        vec_cnt++; if (PCOut !== 16'h0000 || SPOut !== 16'hFFFE) begin err_cnt++; $display("FAIL rb_regs got pc=%h sp=%h want 0000/fffe", PCOut, SPOut); end
        tick();
        Reset = 0;
        MemAck = 1;
        tick();
        MemAck = 0;
        vec_cnt++; if (MemBusy !== 1'b0 || MemDone !== 1'b0 || MDROut !== 16'h0000) begin err_cnt++; $display("FAIL rb_idle got busy=%b done=%b mdr=%h want 0/0/0000", MemBusy, MemDone, MDROut); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_timeout();
        test_branch();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
